// File: rtl/lfsr_cnt_pkg.sv
// Shared helpers for LFSR-prescaled counters: Galois tap table, step function, parameter checks.
// Linear order for readout: SEED is position 0, position n is SEED stepped n times.
package lfsr_cnt_pkg;

    localparam int unsigned LFSR_W_MIN = 3;
    localparam int unsigned LFSR_W_MAX = 16;
    localparam int unsigned HI_W_MIN   = 1;
    localparam int unsigned HI_W_MAX   = 64;

    // Right-shift Galois masks giving a maximal-length sequence for each width.
    function automatic logic [15:0] lfsr_taps(input int unsigned width);
        logic [15:0] taps;
        case (width)
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] q, input logic [15:0] taps);
        return (q >> 1) ^ (q[0] ? taps : 16'h0000);
    endfunction

    function automatic bit lfsr_params_ok(input int unsigned lfsr_w, input int unsigned hi_w,
                                          input logic [15:0] seed);
        return (lfsr_w >= LFSR_W_MIN) && (lfsr_w <= LFSR_W_MAX) &&
               (hi_w >= HI_W_MIN) && (hi_w <= HI_W_MAX) && (seed != 16'h0000);
    endfunction

endpackage

// File: rtl/galois_lfsr_step.sv
// Combinational single step of a Galois LFSR; flags the step that returns to SEED.
module galois_lfsr_step
    import lfsr_cnt_pkg::*;
#(
    parameter int unsigned       LFSR_W = 6,
    parameter logic [LFSR_W-1:0] SEED   = '1
) (
    input  logic [LFSR_W-1:0] q,
    output logic [LFSR_W-1:0] nxt,
    output logic              wrap
);

    localparam logic [15:0] TAPS = lfsr_taps(LFSR_W);

    logic [15:0] nxt_full;

    always_comb begin
        nxt_full = lfsr_next(16'(q), TAPS);
        nxt      = nxt_full[LFSR_W-1:0];
        // Bits above LFSR_W are always zero, so comparing the full word is exact.
        wrap     = (nxt_full == 16'(SEED));
    end

endmodule

// File: rtl/lfsr_prescaled_counter.sv
// Wide event counter: Galois LFSR prescaler feeding a binary high field, with compare match,
// modulo reload, sticky overflow and coherent snapshot capture.
module lfsr_prescaled_counter
    import lfsr_cnt_pkg::*;
#(
    parameter int unsigned       LFSR_W = 6,
    parameter int unsigned       HI_W   = 58,
    parameter logic [LFSR_W-1:0] SEED   = '1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     auto_rld,
    input  logic [LFSR_W+HI_W-1:0]   match_val,
    input  logic                     cap,
    output logic [LFSR_W-1:0]        lfsr_q,
    output logic [HI_W-1:0]          hi_q,
    output logic                     carry,
    output logic                     match,
    output logic                     ovf,
    output logic [LFSR_W+HI_W-1:0]   snap_q,
    output logic                     snap_vld
);

    if (!lfsr_params_ok(LFSR_W, HI_W, 16'(SEED))) begin : g_param_check
        $error("lfsr_prescaled_counter: illegal LFSR_W, HI_W or SEED");
    end

    logic [LFSR_W-1:0] lfsr_nxt;
    logic              step_wrap;
    logic              hit;
    logic [LFSR_W-1:0] lfsr_d;
    logic [HI_W-1:0]   hi_d;
    logic              carry_d;
    logic              match_d;
    logic              ovf_d;

    galois_lfsr_step #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_step (
        .q    (lfsr_q),
        .nxt  (lfsr_nxt),
        .wrap (step_wrap)
    );

    // A zero LFSR field is unreachable, so such a compare value is treated as disabled.
    assign hit = en && ({hi_q, lfsr_q} == match_val) && (match_val[LFSR_W-1:0] != '0);

    always_comb begin
        lfsr_d  = lfsr_q;
        hi_d    = hi_q;
        ovf_d   = ovf;
        carry_d = 1'b0;
        match_d = 1'b0;
        if (clr) begin
            lfsr_d = SEED;
            hi_d   = '0;
            ovf_d  = 1'b0;
        end else if (en) begin
            match_d = hit;
            carry_d = step_wrap;
            if (hit && auto_rld) begin
                // Reload wins over the wrap increment; carry still reports the wrap.
                lfsr_d = SEED;
                hi_d   = '0;
            end else begin
                lfsr_d = lfsr_nxt;
                if (step_wrap) begin
                    hi_d = hi_q + 1'b1;
                    if (&hi_q) begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q   <= SEED;
            hi_q     <= '0;
            carry    <= 1'b0;
            match    <= 1'b0;
            ovf      <= 1'b0;
            snap_q   <= '0;
            snap_vld <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            hi_q     <= hi_d;
            carry    <= carry_d;
            match    <= match_d;
            ovf      <= ovf_d;
            snap_vld <= cap;
            if (cap) begin
                snap_q <= {hi_q, lfsr_q};
            end
        end
    end

endmodule

// File: tb/tb_lfsr_prescaled_counter.sv
// Scoreboard bench: a position/period model predicts each cycle's outputs for two widths of the
// counter; a monitor pops and compares after every clock edge.
module tb_lfsr_prescaled_counter;

    localparam int unsigned LW     = 6;
    localparam int unsigned HWB    = 58;
    localparam int unsigned HWS    = 2;
    localparam int          PERIOD = 63;

    typedef struct packed {
        logic [15:0] lfsr;
        logic [63:0] hi;
        logic        carry;
        logic        match;
        logic        ovf;
        logic        snap_vld;
        logic [15:0] snap_lfsr;
        logic [63:0] snap_hi;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, clr = 1'b0, auto_rld = 1'b0, cap = 1'b0;
    logic [LW+HWB-1:0] mv_big = '0;
    logic [LW+HWS-1:0] mv_small = '0;

    logic [LW-1:0]     lfsr_q0, lfsr_q1;
    logic [HWB-1:0]    hi_q0;
    logic [HWS-1:0]    hi_q1;
    logic              carry0, carry1, match0, match1, ovf0, ovf1, snap_vld0, snap_vld1;
    logic [LW+HWB-1:0] snap_q0;
    logic [LW+HWS-1:0] snap_q1;

    always #5 clk = ~clk;

    lfsr_prescaled_counter #(.LFSR_W(LW), .HI_W(HWB), .SEED(6'h3F)) u_dut_big (
        .clk (clk), .rst (rst), .en (en), .clr (clr), .auto_rld (auto_rld),
        .match_val (mv_big), .cap (cap), .lfsr_q (lfsr_q0), .hi_q (hi_q0),
        .carry (carry0), .match (match0), .ovf (ovf0), .snap_q (snap_q0),
        .snap_vld (snap_vld0)
    );

    lfsr_prescaled_counter #(.LFSR_W(LW), .HI_W(HWS), .SEED(6'h3F)) u_dut_small (
        .clk (clk), .rst (rst), .en (en), .clr (clr), .auto_rld (auto_rld),
        .match_val (mv_small), .cap (cap), .lfsr_q (lfsr_q1), .hi_q (hi_q1),
        .carry (carry1), .match (match1), .ovf (ovf1), .snap_q (snap_q1),
        .snap_vld (snap_vld1)
    );

    exp_t got0, got1;
    always_comb begin
        got0 = '{lfsr: 16'(lfsr_q0), hi: 64'(hi_q0), carry: carry0, match: match0, ovf: ovf0,
                 snap_vld: snap_vld0, snap_lfsr: 16'(snap_q0[LW-1:0]),
                 snap_hi: 64'(snap_q0[LW+HWB-1:LW])};
        got1 = '{lfsr: 16'(lfsr_q1), hi: 64'(hi_q1), carry: carry1, match: match1, ovf: ovf1,
                 snap_vld: snap_vld1, snap_lfsr: 16'(snap_q1[LW-1:0]),
                 snap_hi: 64'(snap_q1[LW+HWS-1:LW])};
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int i, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h exp=%h at %0t", name, i, got, exp, $time);
        end
    endtask

    // Reference: LFSR state at each linear position, from the Galois rule starting at SEED.
    logic [LW-1:0] seq [PERIOD];
    initial begin
        logic [LW-1:0] s;
        s = 6'h3F;
        for (int p = 0; p < PERIOD; p++) begin
            seq[p] = s;
            s = (s >> 1) ^ (s[0] ? 6'h30 : 6'h00);
        end
    end

    int          m_pos   [2];
    logic [63:0] m_hi    [2];
    bit          m_ovf   [2], m_carry [2], m_match [2], m_sv [2];
    logic [63:0] m_shi   [2];
    logic [15:0] m_slfsr [2];
    logic [63:0] mask    [2] = '{64'h03FF_FFFF_FFFF_FFFF, 64'h3};

    exp_t exp_q0 [$], exp_q1 [$];
    logic [79:0] snapq0 [$], snapq1 [$];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = 0; m_hi[i] = '0; m_ovf[i] = 0; m_carry[i] = 0; m_match[i] = 0;
            m_sv[i] = 0; m_shi[i] = '0; m_slfsr[i] = '0;
        end
    endtask

    task automatic model_step(input int i, input bit e, input bit c, input bit a, input bit k,
                              input int mpos, input logic [63:0] mhi);
        bit hit, wrapping;
        m_sv[i] = k;
        if (k) begin
            m_shi[i]   = m_hi[i];
            m_slfsr[i] = 16'(seq[m_pos[i]]);
            if (i == 0) snapq0.push_back({m_shi[i], m_slfsr[i]});
            else        snapq1.push_back({m_shi[i], m_slfsr[i]});
        end
        m_carry[i] = 0;
        m_match[i] = 0;
        if (c) begin
            m_pos[i] = 0; m_hi[i] = '0; m_ovf[i] = 0;
        end else if (e) begin
            hit      = (mpos >= 0) && (m_pos[i] == mpos) && (m_hi[i] == (mhi & mask[i]));
            wrapping = (m_pos[i] == PERIOD - 1);
            m_match[i] = hit;
            m_carry[i] = wrapping;
            if (hit && a) begin
                m_pos[i] = 0; m_hi[i] = '0;
            end else begin
                m_pos[i] = (m_pos[i] + 1) % PERIOD;
                if (wrapping) begin
                    if (m_hi[i] == mask[i]) m_ovf[i] = 1;
                    m_hi[i] = (m_hi[i] + 64'd1) & mask[i];
                end
            end
        end
    endtask

    function automatic exp_t model_out(input int i);
        exp_t x;
        x.lfsr = 16'(seq[m_pos[i]]);
        x.hi = m_hi[i];
        x.carry = m_carry[i];
        x.match = m_match[i];
        x.ovf = m_ovf[i];
        x.snap_vld = m_sv[i];
        x.snap_lfsr = m_slfsr[i];
        x.snap_hi = m_shi[i];
        return x;
    endfunction

    // Drives one cycle's inputs; any check made right after a call sees the previous call's step.
    task automatic cycle(input bit e, input bit c, input bit a, input bit k, input int mpos,
                         input logic [63:0] mhi);
        logic [LW-1:0] lf;
        @(posedge clk);
        #2;
        lf = (mpos < 0) ? 6'h00 : seq[mpos];
        en = e; clr = c; auto_rld = a; cap = k;
        mv_big = {mhi[HWB-1:0], lf};
        mv_small = {mhi[HWS-1:0], lf};
        for (int i = 0; i < 2; i++) model_step(i, e, c, a, k, mpos, mhi);
        exp_q0.push_back(model_out(0));
        exp_q1.push_back(model_out(1));
    endtask

    task automatic cmp_all(input int i, input exp_t g, input exp_t x);
        chk("lfsr_q", i, 64'(g.lfsr), 64'(x.lfsr));
        chk("hi_q", i, g.hi, x.hi);
        chk("carry", i, 64'(g.carry), 64'(x.carry));
        chk("match", i, 64'(g.match), 64'(x.match));
        chk("ovf", i, 64'(g.ovf), 64'(x.ovf));
        chk("snap_vld", i, 64'(g.snap_vld), 64'(x.snap_vld));
        chk("snap_lfsr", i, 64'(g.snap_lfsr), 64'(x.snap_lfsr));
        chk("snap_hi", i, g.snap_hi, x.snap_hi);
    endtask

    task automatic rst_chk(input string name);
        exp_t r;
        r = '{lfsr: 16'h003F, hi: 64'd0, carry: 1'b0, match: 1'b0, ovf: 1'b0, snap_vld: 1'b0,
              snap_lfsr: 16'h0, snap_hi: 64'd0};
        $display("checking reset state: %s", name);
        cmp_all(0, got0, r);
        cmp_all(1, got1, r);
    endtask

    // Monitor: one expectation per clock edge, plus a snapshot pop whenever snap_vld shows.
    initial begin
        exp_t x;
        logic [79:0] s;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (exp_q0.size() > 0) begin x = exp_q0.pop_front(); cmp_all(0, got0, x); end
                if (exp_q1.size() > 0) begin x = exp_q1.pop_front(); cmp_all(1, got1, x); end
                if (snap_vld0) begin
                    if (snapq0.size() == 0) chk("snap_unexpected", 0, 64'd1, 64'd0);
                    else begin
                        s = snapq0.pop_front();
                        chk("snap_pop_hi", 0, got0.snap_hi, s[79:16]);
                        chk("snap_pop_lfsr", 0, 64'(got0.snap_lfsr), 64'(s[15:0]));
                    end
                end
                if (snap_vld1) begin
                    if (snapq1.size() == 0) chk("snap_unexpected", 1, 64'd1, 64'd0);
                    else begin
                        s = snapq1.pop_front();
                        chk("snap_pop_hi", 1, got1.snap_hi, s[79:16]);
                        chk("snap_pop_lfsr", 1, 64'(got1.snap_lfsr), 64'(s[15:0]));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int mpos, r;
        bit a;
        logic [63:0] mhi;
        model_reset();
        #12;
        rst_chk("initial");
        rst = 1'b0;

        // Free-run: one period, then two.
        for (int n = 1; n <= 127; n++) begin
            cycle(1, 0, 0, 0, -1, 64'd0);
            if (n == 64) begin
                chk("p1_lfsr", 0, 64'(lfsr_q0), 64'h3F);
                chk("p1_hi", 0, 64'(hi_q0), 64'd1);
                chk("p1_carry", 0, 64'(carry0), 64'd1);
            end
        end
        chk("p2_hi", 0, 64'(hi_q0), 64'd2);
        chk("p2_hi", 1, 64'(hi_q1), 64'd2);

        // Narrow high field wraps after four periods.
        for (int n = 128; n <= 252; n++) cycle(1, 0, 0, 0, -1, 64'd0);
        cycle(1, 1, 0, 0, -1, 64'd0);
        chk("wrap_hi", 1, 64'(hi_q1), 64'd0);
        chk("wrap_ovf", 1, 64'(ovf1), 64'd1);
        chk("wrap_hi", 0, 64'(hi_q0), 64'd4);
        chk("wrap_ovf", 0, 64'(ovf0), 64'd0);
        cycle(0, 0, 0, 0, -1, 64'd0);
        chk("clr_ovf", 1, 64'(ovf1), 64'd0);
        chk("clr_lfsr", 1, 64'(lfsr_q1), 64'h3F);
        chk("clr_hi", 1, 64'(hi_q1), 64'd0);

        // Modulo mode at {hi=1, position 5}: period of 69 enabled cycles.
        for (int n = 0; n < 217; n++) cycle(1, 0, 1, 0, 5, 64'd1);
        cycle(0, 1, 0, 0, -1, 64'd0);

        // Alternating enable: 63 steps in 126 cycles.
        for (int n = 0; n < 126; n++) cycle(n % 2 == 0, 0, 0, 0, -1, 64'd0);
        cycle(0, 0, 0, 0, -1, 64'd0);
        chk("tog_hi", 0, 64'(hi_q0), 64'd1);
        chk("tog_lfsr", 0, 64'(lfsr_q0), 64'h3F);

        // Capture coinciding with a wrap and a clear.
        cycle(0, 1, 0, 0, -1, 64'd0);
        for (int n = 0; n < 62; n++) cycle(1, 0, 0, 0, -1, 64'd0);
        cycle(1, 1, 0, 1, -1, 64'd0);
        cycle(0, 0, 0, 0, -1, 64'd0);
        chk("capclr_vld", 0, 64'(snap_vld0), 64'd1);
        chk("capclr_snap", 0, 64'(snap_q0), {58'd0, seq[PERIOD-1]});
        chk("capclr_lfsr", 0, 64'(lfsr_q0), 64'h3F);
        chk("capclr_hi", 0, 64'(hi_q0), 64'd0);

        // Randomised traffic, match_val changed mid-count.
        mpos = -1; mhi = '0; a = 0;
        for (int n = 0; n < 2500; n++) begin
            if (n % 150 == 0) begin
                r = int'($urandom_range(0, 75));
                mpos = (r > PERIOD - 1) ? -1 : r;
                mhi = 64'($urandom_range(0, 2));
                a = bit'($urandom_range(0, 1));
            end
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 399) == 0, a,
                  $urandom_range(0, 7) == 0, mpos, mhi);
        end

        // Asynchronous reset between edges, then resume from SEED.
        for (int n = 0; n < 30; n++) cycle(1, 0, 0, 0, -1, 64'd0);
        #2;
        rst = 1'b1;
        exp_q0.delete(); exp_q1.delete(); snapq0.delete(); snapq1.delete();
        #1;
        rst_chk("async");
        @(posedge clk);
        #2;
        en = 0; clr = 0; cap = 0; auto_rld = 0;
        model_reset();
        rst = 1'b0;
        for (int n = 0; n < 70; n++) cycle(1, 0, 0, n % 9 == 0, -1, 64'd0);

        @(posedge clk);
        #3;
        chk("drain_exp", 0, 64'(exp_q0.size() + exp_q1.size()), 64'd0);
        chk("drain_snap", 0, 64'(snapq0.size() + snapq1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_prescaled_counter.md
Name: lfsr_prescaled_counter

Overview:
Parametrised wide event counter. The low field is a maximal-length Galois LFSR prescaler; the high field is a binary counter that advances once per full LFSR period. Adds the following features:
- programmable compare match
- optional auto-reload (modulo) mode
- sticky overflow
- coherent snapshot capture
Sits between event sources (count enables) and the register/readout layer, replacing fixed-width LFSR+binary counter chains.

Parameters:
LFSR_W, 6, prescaler width, legal 3..16; period 2^LFSR_W-1
HI_W, 58, binary high-field width, legal 1..64
SEED, all-ones of LFSR_W, LFSR reset/reload state, must be nonzero

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  count enable; one step per cycle when high
clr  in  1  synchronous clear to reset state; also clears ovf
auto_rld  in  1  1 = modulo mode, reload on match; 0 = free-run
match_val  in  LFSR_W+HI_W  compare value, {hi, lfsr} format
cap  in  1  snapshot request
lfsr_q  out  LFSR_W  current prescaler state
hi_q  out  HI_W  current high count
carry  out  1  registered pulse, LFSR completed a period
match  out  1  registered pulse, counter equalled match_val while enabled
ovf  out  1  sticky, high field wrapped
snap_q  out  LFSR_W+HI_W  captured {hi_q, lfsr_q}
snap_vld  out  1  pulse, snap_q updated this cycle

Behaviour:
- Reset (async assert, sync release is the integrator's job): lfsr_q=SEED, hi_q=0, carry=0, match=0, ovf=0, snap_q=0, snap_vld=0.
- LFSR step (Galois, right shift): nxt = (q>>1) ^ (q[0] ? TAPS : 0). TAPS comes from the package table indexed by LFSR_W.
- Prescaler period: the LFSR visits 2^LFSR_W-1 states, never zero.
- Wrap: when en=1 and nxt==SEED, this is a wrap cycle.
  - lfsr_q becomes SEED.
  - hi_q increments mod 2^HI_W.
  - carry=1 on the following cycle (1-cycle latency, registered).
- Overflow: a wrap cycle with hi_q all-ones sets hi_q=0 and ovf=1. ovf holds until clr or rst.
- Match: when en=1 and {hi_q,lfsr_q}==match_val, match=1 next cycle.
  - If auto_rld=1 in the same cycle, the next state is lfsr_q=SEED, hi_q=0 instead of stepping. The period is therefore (match position + 1) enabled cycles.
  - No carry is generated by a reload unless that step was also a wrap; reload takes priority over the wrap increment.
- en=0: all state holds. carry and match are 0.
- Priority, highest first: rst > clr > auto-reload > normal step.
  - clr forces the reset state of lfsr_q, hi_q and ovf. carry and match are 0 on the next cycle.
- Capture: cap=1 latches the pre-edge {hi_q,lfsr_q} into snap_q. snap_vld=1 on the next cycle.
  - cap coincident with en, wrap or clr captures the value before that update.
  - snap_q is independent of clr; only rst clears it.
- match_val is sampled combinationally each cycle. Changing it mid-count takes effect immediately.
  - A match_val whose LFSR field is zero never matches.
- Counter linear order for software: SEED is position 0. The package provides a mapping note but no in-block decode; the readout layer does the position decode.

Decomposition:
- Package lfsr_cnt_pkg holds:
  - function lfsr_taps(width), returning Galois masks for widths 3..16 (hex): 6,C,14,30,60,B8,110,240,500,829,100D,2015,6000,D008
  - function lfsr_next(q, taps)
  - elaboration-time assertion constraints on LFSR_W, HI_W and SEED≠0
- One natural sub-module: galois_lfsr_step, combinational, producing nxt and wrap (nxt==SEED). It is reused by the future down-counter variant.
- The main module holds the registers, match/reload logic, ovf and snapshot.

Test Plan:
Defaults, en=1 held, auto_rld=0:
- After 63 cycles: lfsr_q=3F, hi_q=1, carry pulses exactly once, at cycle 64.
- After 126 cycles: hi_q=2.

HI_W=2, en=1 for 4×63=252 cycles:
- hi_q wraps 3→0 and ovf=1.
- clr pulse → ovf=0, lfsr_q=3F, hi_q=0 the next cycle.

auto_rld=1, match_val={hi=1, lfsr at position 5}:
- match pulses every 69 enabled cycles.
- hi_q never exceeds 1.
- carry pulses once per period.

en toggled 1/0 alternately for 126 cycles:
- hi_q=1, lfsr_q=3F.
- No carry or match while en=0.

Async rst asserted mid-count, not on a clock edge:
- All outputs reach reset values immediately.
- Counting resumes from SEED after release.

cap asserted on the same edge as a wrap and a clr:
- snap_q={0,pre-wrap lfsr state}, snap_vld=1.
- Counter returns to reset state.
